l1_cache_nway: RTL and testbench

- Parameterised N-way set-associative, write-back, write-allocate L1 cache: datapath plus control FSM in one block.
- Sits between the pipeline MEM stage (32-bit word port) and the arbiter/L2 (256-bit line port).
- Generalises the fixed 2-way/8-set data cache to configurable ways and sets.
- Adds tree pseudo-LRU, invalid-first victim selection and hit/miss performance counters.

---
 rtl/l1_cache_nway.sv | 194 +++++++++++++++++++
 tb/tb_l1_cache_nway.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/l1_cache_nway.sv
// N-way set-associative write-back/write-allocate L1: read/write hits complete in the request cycle,
// misses stall (mem_resp low) through an optional line writeback and a line fill from pmem.
module l1_cache_nway #(
  parameter int WAYS    = 4,
  parameter int S_INDEX = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_wdata,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  localparam int SETS = 1 << S_INDEX;
  localparam int T    = 27 - S_INDEX;
  localparam int WW   = $clog2(WAYS);

  typedef logic [7:0][31:0] line_t;
  typedef enum logic [1:0] {CHECK, WRITEBACK, ALLOCATE} state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   victim_q, victim_d;
  logic [31:0]     hit_cnt_q, miss_cnt_q;
  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] dirty_q [SETS];
  logic [WAYS-2:0] plru_q  [SETS];
  logic [T-1:0]    tag_q   [SETS][WAYS];
  line_t           data_q  [SETS][WAYS];

  logic [S_INDEX-1:0] set_idx;
  logic [T-1:0]       addr_tag;
  logic [2:0]         word_sel;
  logic               req, hit, inv_found;
  logic [WW-1:0]      hit_way, inv_way;
  logic               hit_we, fill_we, wb_done, miss;
  line_t              hit_line, merged_line;
  logic               unused_addr_lsb;

  assign set_idx         = mem_address[4+S_INDEX:5];
  assign addr_tag        = mem_address[31:5+S_INDEX];
  assign word_sel        = mem_address[4:2];
  assign req             = mem_read | mem_write;
  assign unused_addr_lsb = ^mem_address[1:0];

  // Tree walk: level l holds nodes (2^l - 1) .. (2^(l+1) - 2); the way prefix picks the node.
  function automatic logic [WW-1:0] plru_victim(input logic [WAYS-2:0] bits);
    logic [WW-1:0] way;
    way = '0;
    for (int l = 0; l < WW; l++)
      for (int n = (1 << l) - 1; n < (2 << l) - 1; n++)
        if (n - ((1 << l) - 1) == int'(way >> (WW - l))) way[WW-1-l] = bits[n];
    return way;
  endfunction

  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits, input logic [WW-1:0] w);
    logic [WAYS-2:0] nb;
    nb = bits;
    for (int l = 0; l < WW; l++)
      for (int n = (1 << l) - 1; n < (2 << l) - 1; n++)
        if (n - ((1 << l) - 1) == int'(w >> (WW - l))) nb[n] = ~w[WW-1-l];
    return nb;
  endfunction

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid_q[set_idx][w] && tag_q[set_idx][w] == addr_tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[set_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WW'(w);
      end
    victim_d = inv_found ? inv_way : plru_victim(plru_q[set_idx]);
  end

  assign hit_line   = data_q[set_idx][hit_way];
  assign mem_rdata  = hit_line[word_sel];
  assign pmem_wdata = data_q[set_idx][victim_q];
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  always_comb begin
    merged_line = hit_line;
    for (int b = 0; b < 4; b++)
      if (mem_byte_enable[b]) merged_line[word_sel][b*8 +: 8] = mem_wdata[b*8 +: 8];
  end

  always_comb begin
    state_d      = state_q;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    hit_we       = 1'b0;
    fill_we      = 1'b0;
    wb_done      = 1'b0;
    miss         = 1'b0;
    case (state_q)
      CHECK: begin
        if (req && hit) begin
          mem_resp = 1'b1;
          hit_we   = mem_write;
        end else if (req) begin
          miss    = 1'b1;
          state_d = (valid_q[set_idx][victim_d] && dirty_q[set_idx][victim_d]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[set_idx][victim_q], set_idx, 5'b0};
        if (pmem_resp) begin
          wb_done = 1'b1;
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {addr_tag, set_idx, 5'b0};
        if (pmem_resp) begin
          fill_we = 1'b1;
          state_d = CHECK;
        end
      end
      default: state_d = CHECK;
    endcase
    // Reset aborts any in-flight miss: nothing leaves the block while rst is high.
    if (rst) begin
      mem_resp   = 1'b0;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      hit_we     = 1'b0;
      fill_we    = 1'b0;
      wb_done    = 1'b0;
      miss       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CHECK;
      victim_q   <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q <= state_d;
      if (miss) begin
        victim_q   <= victim_d;
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
      if (mem_resp) begin
        hit_cnt_q       <= hit_cnt_q + 32'd1;
        plru_q[set_idx] <= plru_touch(plru_q[set_idx], hit_way);
      end
      if (hit_we) dirty_q[set_idx][hit_way] <= 1'b1;
      if (wb_done) dirty_q[set_idx][victim_q] <= 1'b0;
      if (fill_we) begin
        valid_q[set_idx][victim_q] <= 1'b1;
        dirty_q[set_idx][victim_q] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (hit_we) data_q[set_idx][hit_way] <= merged_line;
    if (fill_we) begin
      data_q[set_idx][victim_q] <= pmem_rdata;
      tag_q[set_idx][victim_q]  <= addr_tag;
    end
  end

endmodule

// File: tb/tb_l1_cache_nway.sv
// Directed bench for l1_cache_nway: a 4-way instance for most scenarios and a 2-way instance
// for the alternating-victim case; a small pmem responder answers every line request in one cycle.
module tb_l1_cache_nway;

  logic         clk = 1'b0;
  logic         rst, dsel;
  logic [31:0]  mem_address, mem_wdata;
  logic         mem_read, mem_write, pmem_resp, resp4, resp2;
  logic [3:0]   mem_byte_enable;
  logic [255:0] pmem_rdata, fill_line;

  logic [31:0]  rdata4, rdata2, paddr4, paddr2, hits4, hits2, miss4, miss2;
  logic         resp_o4, resp_o2, pread4, pread2, pwrite4, pwrite2;
  logic [255:0] pwdata4, pwdata2;

  logic [31:0]  c_rdata, c_paddr, c_hits, c_miss;
  logic         c_resp, c_pread, c_pwrite;
  logic [255:0] c_pwdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign resp4 = pmem_resp & ~dsel;
  assign resp2 = pmem_resp & dsel;

  assign c_rdata  = dsel ? rdata2  : rdata4;
  assign c_resp   = dsel ? resp_o2 : resp_o4;
  assign c_paddr  = dsel ? paddr2  : paddr4;
  assign c_pread  = dsel ? pread2  : pread4;
  assign c_pwrite = dsel ? pwrite2 : pwrite4;
  assign c_pwdata = dsel ? pwdata2 : pwdata4;
  assign c_hits   = dsel ? hits2   : hits4;
  assign c_miss   = dsel ? miss2   : miss4;

  l1_cache_nway #(.WAYS(4), .S_INDEX(3)) u_dut4 (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata), .mem_rdata(rdata4), .mem_resp(resp_o4),
    .pmem_address(paddr4), .pmem_read(pread4), .pmem_write(pwrite4), .pmem_wdata(pwdata4),
    .pmem_rdata(pmem_rdata), .pmem_resp(resp4), .hit_count(hits4), .miss_count(miss4)
  );

  l1_cache_nway #(.WAYS(2), .S_INDEX(3)) u_dut2 (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata), .mem_rdata(rdata2), .mem_resp(resp_o2),
    .pmem_address(paddr2), .pmem_read(pread2), .pmem_write(pwrite2), .pmem_wdata(pwdata2),
    .pmem_rdata(pmem_rdata), .pmem_resp(resp2), .hit_count(hits2), .miss_count(miss2)
  );

  // Entered and left at a falling edge. Reports the cycle (from request) at which mem_resp,
  // the first writeback and the first fill appeared; -1 means never seen.
  task automatic do_access(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wd, output logic [31:0] rd, output int cyc,
                           output int wc, output logic [31:0] wa, output logic [255:0] wdat,
                           output int fc, output logic [31:0] fa);
    rd = '0; cyc = -1; wc = -1; wa = '0; wdat = '0; fc = -1; fa = '0;
    mem_address = addr; mem_read = ~wr; mem_write = wr; mem_byte_enable = be; mem_wdata = wd;
    for (int c = 0; c < 40; c++) begin
      pmem_resp = 1'b0;
      #1;
      if (c_resp) begin
        rd = c_rdata; cyc = c;
        break;
      end
      if (c_pwrite) begin
        if (wc < 0) begin wc = c; wa = c_paddr; wdat = c_pwdata; end
        pmem_resp = 1'b1;
      end else if (c_pread) begin
        if (fc < 0) begin fc = c; fa = c_paddr; end
        pmem_rdata = fill_line;
        pmem_resp  = 1'b1;
      end
      @(negedge clk);
    end
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
  endtask

  task automatic apply_reset();
    mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++; if (resp_o4 !== 1'b0 || resp_o2 !== 1'b0) begin errors++; $display("FAIL reset_mem_resp: got %b/%b want 0", resp_o4, resp_o2); end
    checks++; if (pread4 !== 1'b0 || pwrite4 !== 1'b0) begin errors++; $display("FAIL reset_pmem4: got rd=%b wr=%b want 0", pread4, pwrite4); end
    checks++; if (pread2 !== 1'b0 || pwrite2 !== 1'b0) begin errors++; $display("FAIL reset_pmem2: got rd=%b wr=%b want 0", pread2, pwrite2); end
    checks++; if (hits4 !== 32'd0 || miss4 !== 32'd0) begin errors++; $display("FAIL reset_counters: got hit=%0d miss=%0d want 0", hits4, miss4); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cold_read_write();
    logic [31:0] rd, wa, fa; logic [255:0] wdat; int cyc, wc, fc;
    apply_reset();
    for (int i = 0; i < 8; i++) fill_line[i*32 +: 32] = 32'h1111_0000 + i;
    fill_line[63:32] = 32'hDEADBEEF;
    do_access(1'b0, 32'h0000_1024, 4'h0, 32'h0, rd, cyc, wc, wa, wdat, fc, fa);
    checks++; if (fa !== 32'h0000_1020 || fc !== 1) begin errors++; $display("FAIL cold_fill: got addr=%h cyc=%0d want 00001020 cyc 1", fa, fc); end
    checks++; if (wc !== -1) begin errors++; $display("FAIL cold_no_wb: got wb cycle %0d want none", wc); end
    checks++; if (cyc !== 2 || rd !== 32'hDEADBEEF) begin errors++; $display("FAIL cold_rdata: got %h at cyc %0d want deadbeef at 2", rd, cyc); end
    checks++; if (miss4 !== 32'd1 || hits4 !== 32'd1) begin errors++; $display("FAIL cold_counts: got miss=%0d hit=%0d want 1/1", miss4, hits4); end
    do_access(1'b1, 32'h0000_1024, 4'b0011, 32'h1234_5678, rd, cyc, wc, wa, wdat, fc, fa);
    checks++; if (cyc !== 0 || fc !== -1) begin errors++; $display("FAIL write_hit_lat: got cyc=%0d fill=%0d want 0/none", cyc, fc); end
    do_access(1'b0, 32'h0000_1024, 4'h0, 32'h0, rd, cyc, wc, wa, wdat, fc, fa);
    checks++; if (cyc !== 0 || rd !== 32'hDEAD5678) begin errors++; $display("FAIL write_merge: got %h at cyc %0d want dead5678 at 0", rd, cyc); end
    do_access(1'b0, 32'h0000_1020, 4'h0, 32'h0, rd, cyc, wc, wa, wdat, fc, fa);
    checks++; if (rd !== 32'h1111_0000) begin errors++; $display("FAIL other_word: got %h want 11110000", rd); end
    checks++; if (miss4 !== 32'd1 || hits4 !== 32'd4) begin errors++; $display("FAIL hit_counts: got miss=%0d hit=%0d want 1/4", miss4, hits4); end
  endtask

  task automatic test_plru_victim();
    logic [31:0] rd, wa, fa; logic [255:0] wdat; int cyc, wc, fc;
    logic [31:0] seq [3];
    apply_reset();
    for (int t = 0; t < 4; t++) begin
      do_access(1'b0, 32'h0000_1020 + 32'(t) * 32'h100, 4'h0, 32'h0, rd, cyc, wc, wa, wdat, fc, fa);
      checks++; if (cyc !== 2 || fa !== 32'h0000_1020 + 32'(t) * 32'h100) begin errors++; $display("FAIL plru_fill%0d: got addr=%h cyc=%0d", t, fa, cyc); end
    end
    do_access(1'b0, 32'h0000_1020, 4'h0, 32'h0, rd, cyc, wc, wa, wdat, fc, fa);
    checks++; if (cyc !== 0) begin errors++; $display("FAIL plru_rehit: got cyc=%0d want 0", cyc); end
    do_access(1'b0, 32'h0000_1420, 4'h0, 32'h0, rd, cyc, wc, wa, wdat, fc, fa);
    checks++; if (fa !== 32'h0000_1420 || wc !== -1) begin errors++; $display("FAIL plru_miss: got fill=%h wb=%0d want 00001420/none", fa, wc); end
    seq = '{32'h0000_1020, 32'h0000_1120, 32'h0000_1320};
    for (int k = 0; k < 3; k++) begin
      do_access(1'b0, seq[k], 4'h0, 32'h0, rd, cyc, wc, wa, wdat, fc, fa);
      checks++; if (cyc !== 0) begin errors++; $display("FAIL plru_kept%0d: %h got cyc=%0d want 0", k, seq[k], cyc); end
    end
    do_access(1'b0, 32'h0000_1220, 4'h0, 32'h0, rd, cyc, wc, wa, wdat, fc, fa);
    checks++; if (cyc !== 2 || fa !== 32'h0000_1220) begin errors++; $display("FAIL plru_evicted_way2: got cyc=%0d fill=%h want 2/00001220", cyc, fa); end
    checks++; if (miss4 !== 32'd6 || hits4 !== 32'd10) begin errors++; $display("FAIL plru_counts: got miss=%0d hit=%0d want 6/10", miss4, hits4); end
  endtask

  task automatic test_dirty_victim();
    logic [31:0] rd, wa, fa; logic [255:0] wdat, exp_line; int cyc, wc, fc;
    logic [31:0] seq [3];
    apply_reset();
    for (int i = 0; i < 8; i++) fill_line[i*32 +: 32] = 32'hA0A0_0000 + i;
    exp_line = fill_line;
    exp_line[95:64] = 32'hCAFEF00D;
    do_access(1'b1, 32'h0000_2048, 4'hF, 32'hCAFEF00D, rd, cyc, wc, wa, wdat, fc, fa);
    checks++; if (cyc !== 2 || wc !== -1) begin errors++; $display("FAIL wr_alloc: got cyc=%0d wb=%0d want 2/none", cyc, wc); end
    seq = '{32'h0000_2140, 32'h0000_2240, 32'h0000_2340};
    for (int k = 0; k < 3; k++) do_access(1'b0, seq[k], 4'h0, 32'h0, rd, cyc, wc, wa, wdat, fc, fa);
    do_access(1'b0, 32'h0000_2440, 4'h0, 32'h0, rd, cyc, wc, wa, wdat, fc, fa);
    checks++; if (wc !== 1 || wa !== 32'h0000_2040) begin errors++; $display("FAIL wb_addr: got %h at cyc %0d want 00002040 at 1", wa, wc); end
    checks++; if (wdat !== exp_line) begin errors++; $display("FAIL wb_data: got %h want %h", wdat, exp_line); end
    checks++; if (fc !== 2 || fa !== 32'h0000_2440) begin errors++; $display("FAIL wb_then_fill: got %h at cyc %0d want 00002440 at 2", fa, fc); end
    checks++; if (cyc !== 3 || rd !== 32'hA0A0_0000) begin errors++; $display("FAIL dirty_miss_rd: got %h at cyc %0d want a0a00000 at 3", rd, cyc); end
    seq = '{32'h0000_2240, 32'h0000_2140, 32'h0000_2340};
    for (int k = 0; k < 3; k++) do_access(1'b0, seq[k], 4'h0, 32'h0, rd, cyc, wc, wa, wdat, fc, fa);
    do_access(1'b0, 32'h0000_2540, 4'h0, 32'h0, rd, cyc, wc, wa, wdat, fc, fa);
    checks++; if (wc !== -1 || fc !== 1 || cyc !== 2) begin errors++; $display("FAIL refilled_clean: got wb=%0d fill=%0d cyc=%0d want none/1/2", wc, fc, cyc); end
  endtask

  task automatic test_reset_mid_miss();
    logic [31:0] rd, wa, fa; logic [255:0] wdat; int cyc, wc, fc;
    apply_reset();
    mem_address = 32'h0000_3060; mem_read = 1'b1; mem_write = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (pread4 !== 1'b1 || paddr4 !== 32'h0000_3060) begin errors++; $display("FAIL mid_alloc: got rd=%b addr=%h want 1/00003060", pread4, paddr4); end
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (pread4 !== 1'b0 || pwrite4 !== 1'b0 || resp_o4 !== 1'b0) begin errors++; $display("FAIL mid_abort: got rd=%b wr=%b resp=%b want 0", pread4, pwrite4, resp_o4); end
    checks++; if (miss4 !== 32'd0 || hits4 !== 32'd0) begin errors++; $display("FAIL mid_counters: got miss=%0d hit=%0d want 0", miss4, hits4); end
    rst = 1'b0;
    do_access(1'b0, 32'h0000_3060, 4'h0, 32'h0, rd, cyc, wc, wa, wdat, fc, fa);
    checks++; if (fc !== 1 || cyc !== 2 || miss4 !== 32'd1) begin errors++; $display("FAIL mid_restart: got fill=%0d cyc=%0d miss=%0d want 1/2/1", fc, cyc, miss4); end
  endtask

  task automatic test_two_way();
    logic [31:0] rd, wa, fa; logic [255:0] wdat; int cyc, wc, fc;
    logic [31:0] addrs [6];
    logic [31:0] exp_wb [6];
    dsel = 1'b1;
    apply_reset();
    fill_line = '0;
    addrs  = '{32'h0000_4060, 32'h0000_4160, 32'h0000_4260, 32'h0000_4060, 32'h0000_4160, 32'h0000_4260};
    exp_wb = '{32'h0, 32'h0, 32'h0000_4060, 32'h0000_4160, 32'h0000_4260, 32'h0000_4060};
    for (int k = 0; k < 6; k++) begin
      do_access(1'b1, addrs[k], 4'hF, 32'h5000_0000 + 32'(k), rd, cyc, wc, wa, wdat, fc, fa);
      if (k < 2) begin
        checks++; if (wc !== -1 || fc !== 1) begin errors++; $display("FAIL w2_cold%0d: got wb=%0d fill=%0d want none/1", k, wc, fc); end
      end else begin
        checks++; if (wc !== 1 || wa !== exp_wb[k]) begin errors++; $display("FAIL w2_evict%0d: got %h at %0d want %h at 1", k, wa, wc, exp_wb[k]); end
        checks++; if (wdat[31:0] !== 32'h5000_0000 + 32'(k - 2)) begin errors++; $display("FAIL w2_wbdata%0d: got %h want %h", k, wdat[31:0], 32'h5000_0000 + 32'(k - 2)); end
      end
    end
    checks++; if (miss2 !== 32'd6 || hits2 !== 32'd6) begin errors++; $display("FAIL w2_counts: got miss=%0d hit=%0d want 6/6", miss2, hits2); end
    dsel = 1'b0;
  endtask

  initial begin
    rst = 1'b1; dsel = 1'b0; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    mem_address = '0; mem_byte_enable = '0; mem_wdata = '0; pmem_rdata = '0; fill_line = '0;
    test_reset();
    test_cold_read_write();
    test_plru_victim();
    test_dirty_victim();
    test_reset_mid_miss();
    test_two_way();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
